multi_channel_phase_accumulator: RTL
====================================

Name: multi_channel_phase_accumulator

Overview:
Parametrised N-channel DDS phase accumulator that supersedes the single-channel accumulator. Each channel holds a double-buffered frequency tuning word (FTW), a phase offset and an optional linear frequency sweep. All channels can be retuned on the same clock edge. Outputs feed the waveform lookup stage (sine/square/triangle LUTs) of the signal generator.

Parameters:
CHANNELS, 2, number of independent accumulators
ACC_W, 48, accumulator and FTW width
OUT_W, 12, output phase width, taken from acc[ACC_W-1 -: OUT_W]
CH_AW, 1, channel address width, at least clog2(CHANNELS), minimum 1

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
WR_EN  in  1  write strobe into the shadow register bank
WR_CH  in  CH_AW  target channel; values >= CHANNELS are ignored
WR_SEL  in  2  0=FTW, 1=phase offset (low OUT_W bits), 2=sweep step, 3=sweep limit
WR_DATA  in  ACC_W  write data
UPDATE  in  1  copy all shadow registers to active registers
PHASE_CLR  in  CHANNELS  per-channel accumulator clear
SWEEP_EN  in  CHANNELS  per-channel sweep enable
PHASE  out  CHANNELS*OUT_W  channel c occupies [c*OUT_W +: OUT_W]
WRAP  out  CHANNELS  one-cycle pulse when the channel accumulator overflows
SWEEP_WRAP  out  CHANNELS  one-cycle pulse when the channel sweep restarts

Behaviour:
- RESET: clears all shadow and active registers, accumulators, PHASE, WRAP and SWEEP_WRAP to 0.
- Shadow write: on WR_EN, shadow[WR_CH][WR_SEL] <= WR_DATA. Offset keeps WR_DATA[OUT_W-1:0]. Writes do not touch the active registers.
- UPDATE: active FTW, offset, step and limit <= shadow for every channel. If WR_EN and UPDATE occur in the same cycle, the value being written is forwarded into the active register.
- Accumulator, per cycle: acc <= acc + active_ftw, modulo 2^ACC_W. WRAP[c] is registered and is 1 in the cycle after the addition carries out of bit ACC_W-1.
- Sweep, when SWEEP_EN[c]=1 and UPDATE=0:
  - if active_ftw + step >= limit (unsigned, ACC_W+1-bit compare): active_ftw <= shadow FTW and SWEEP_WRAP[c] pulses next cycle.
  - otherwise active_ftw <= active_ftw + step.
  - The FTW used by the accumulator in a cycle is the pre-update value.
- Sweep disabled: active_ftw holds.
- Step=0 with sweep enabled gives a constant frequency. Limit=0 makes the channel restart the sweep every cycle.
- PHASE_CLR[c]: acc <= 0 this edge, and no WRAP is generated. Active registers and sweep state are unaffected.
- Precedence per channel: RESET > PHASE_CLR (accumulator) ; UPDATE > sweep (FTW).
- Output: PHASE[c] <= acc[ACC_W-1 -: OUT_W] + offset, modulo 2^OUT_W, registered. Latency is 1 cycle from accumulator to PHASE; an FTW change is visible at PHASE 2 cycles after UPDATE.
- Channels are fully independent. No combinational path from any input to any output.
- RESET asserted mid-sweep or mid-write: all state returns to 0 and pending shadow data is lost.

Test Plan:
- Reset/idle: assert RESET 3 cycles, release -> PHASE=0, WRAP=0, SWEEP_WRAP=0; with no writes PHASE stays 0 for 100 cycles.
- Basic tuning (defaults): write ch0 FTW=2^36, pulse UPDATE -> PHASE[0] increments by 1 per cycle starting 2 cycles after UPDATE; 0xFFF->0x000 transition coincides with WRAP[0] pulse; ch1 stays 0.
- Double buffering: ch0 running at FTW=2^36; write FTW=2^37 without UPDATE -> step still 1 for 20 cycles; pulse UPDATE -> step becomes 2. Same-cycle WR_EN+UPDATE with 2^38 -> step 4.
- Offset/clear: ch1 offset=0x800, FTW=0, UPDATE -> PHASE[1]=0x800; FTW=2^36 and offset 0x801 with UPDATE -> PHASE[1] wraps 0xFFF->0x000 correctly modulo 4096; PHASE_CLR[1] -> PHASE[1]=0x801 next cycle, no WRAP.
- Sweep: ch0 FTW=2^36, step=2^36, limit=4*2^36, SWEEP_EN[0]=1 -> active FTW sequence 1,2,3,then reload 1 (×2^36); SWEEP_WRAP[0] pulses every 3 cycles; UPDATE during sweep reloads shadow values and overrides the step.
- Reset mid-operation: RESET during an active sweep on both channels -> all outputs 0 next cycle; after release no activity until a new write and UPDATE.

Source files
------------

// File: rtl/multi_channel_phase_accumulator_if.sv
// Control/status bundle of the multi-channel DDS phase accumulator.
// The master drives the shadow writes and per-channel controls; the slave returns phases and pulses.
interface multi_channel_phase_accumulator_if #(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 48,
  parameter int OUT_W    = 12,
  parameter int CH_AW    = 1
);
  logic                      WR_EN;
  logic [CH_AW-1:0]          WR_CH;
  logic [1:0]                WR_SEL;
  logic [ACC_W-1:0]          WR_DATA;
  logic                      UPDATE;
  logic [CHANNELS-1:0]       PHASE_CLR;
  logic [CHANNELS-1:0]       SWEEP_EN;
  logic [CHANNELS*OUT_W-1:0] PHASE;
  logic [CHANNELS-1:0]       WRAP;
  logic [CHANNELS-1:0]       SWEEP_WRAP;

  modport master (
    output WR_EN, WR_CH, WR_SEL, WR_DATA, UPDATE, PHASE_CLR, SWEEP_EN,
    input  PHASE, WRAP, SWEEP_WRAP
  );

  modport slave (
    input  WR_EN, WR_CH, WR_SEL, WR_DATA, UPDATE, PHASE_CLR, SWEEP_EN,
    output PHASE, WRAP, SWEEP_WRAP
  );
endinterface

// File: rtl/multi_channel_phase_accumulator.sv
// N-channel DDS phase accumulator with double-buffered tuning, phase offset and linear sweep.
// Every output is registered; channels share only the write bus and the UPDATE strobe.
module multi_channel_phase_accumulator #(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 48,
  parameter int OUT_W    = 12,
  parameter int CH_AW    = 1
) (
  input logic CLK,
  input logic RESET,
  multi_channel_phase_accumulator_if.slave bus
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [ACC_W-1:0] sh_ftw, sh_step, sh_lim;
    logic [OUT_W-1:0] sh_off;
    logic [ACC_W-1:0] act_ftw, act_step, act_lim;
    logic [OUT_W-1:0] act_off;
    logic [ACC_W-1:0] acc;
    logic             carry_q, wrap_q, swrap_q;
    logic [OUT_W-1:0] phase_q;

    logic             wr_hit;
    logic [ACC_W-1:0] ftw_fw, step_fw, lim_fw;
    logic [OUT_W-1:0] off_fw;
    logic [ACC_W:0]   acc_sum, sweep_sum;
    logic             sweep_hit;

    assign wr_hit    = bus.WR_EN && (bus.WR_CH == CH_AW'(c));
    assign acc_sum   = {1'b0, acc} + {1'b0, act_ftw};
    assign sweep_sum = {1'b0, act_ftw} + {1'b0, act_step};
    assign sweep_hit = sweep_sum >= {1'b0, act_lim};

    // Shadow contents after this edge's write; also the forwarded value for a same-cycle UPDATE.
    always_comb begin
      ftw_fw  = sh_ftw;
      off_fw  = sh_off;
      step_fw = sh_step;
      lim_fw  = sh_lim;
      if (wr_hit) begin
        case (bus.WR_SEL)
          2'd0:    ftw_fw  = bus.WR_DATA;
          2'd1:    off_fw  = bus.WR_DATA[OUT_W-1:0];
          2'd2:    step_fw = bus.WR_DATA;
          default: lim_fw  = bus.WR_DATA;
        endcase
      end
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        sh_ftw   <= '0;
        sh_off   <= '0;
        sh_step  <= '0;
        sh_lim   <= '0;
        act_ftw  <= '0;
        act_off  <= '0;
        act_step <= '0;
        act_lim  <= '0;
        acc      <= '0;
        carry_q  <= 1'b0;
        wrap_q   <= 1'b0;
        swrap_q  <= 1'b0;
        phase_q  <= '0;
      end else begin
        sh_ftw  <= ftw_fw;
        sh_off  <= off_fw;
        sh_step <= step_fw;
        sh_lim  <= lim_fw;
        swrap_q <= 1'b0;
        if (bus.UPDATE) begin
          act_ftw  <= ftw_fw;
          act_off  <= off_fw;
          act_step <= step_fw;
          act_lim  <= lim_fw;
        end else if (bus.SWEEP_EN[c]) begin
          if (sweep_hit) begin
            act_ftw <= sh_ftw;
            swrap_q <= 1'b1;
          end else begin
            act_ftw <= sweep_sum[ACC_W-1:0];
          end
        end
        acc     <= bus.PHASE_CLR[c] ? '0 : acc_sum[ACC_W-1:0];
        // Carry is held one extra stage so WRAP lines up with the wrapped value on PHASE.
        carry_q <= acc_sum[ACC_W] & ~bus.PHASE_CLR[c];
        wrap_q  <= carry_q;
        phase_q <= acc[ACC_W-1 -: OUT_W] + act_off;
      end
    end

    assign bus.PHASE[c*OUT_W +: OUT_W] = phase_q;
    assign bus.WRAP[c]                 = wrap_q;
    assign bus.SWEEP_WRAP[c]           = swrap_q;
  end

endmodule
